rr_lock_scheduler: RTL and testbench

- 4-requester round-robin scheduler for a shared, non-preemptible resource, e.g. a single bus or datapath port.
- A grant is held (locked) by the winning requester until it signals done, drops its request, or hits a hold-time limit.
- After each release, the next requester in round-robin order is picked, and there is one guaranteed dead cycle between owners.
- Sits between requesting masters and the shared resource's mux select.

---
 rtl/rr_lock_scheduler.sv | 110 +++++++++++
 tb/tb_rr_lock_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_lock_scheduler.sv
// rr_lock_scheduler: four-requester round-robin scheduler for a shared,
// non-preemptible resource. The winning requester keeps its grant until it
// pulses done, drops its request, or reaches the MAX_HOLD cycle limit.
// Every release is followed by at least one idle cycle before the next owner.
module rr_lock_scheduler #(
  parameter int NREQ     = 4,   // fixed at 4; the owner index is 2 bits wide
  parameter int MAX_HOLD = 16,  // longest grant, in cycles (2..255)
  parameter int CNT_W    = 8    // hold counter width, 2**CNT_W > MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  done,
  output logic [NREQ-1:0]  grant,
  output logic             busy,
  output logic [1:0]       owner_id,
  output logic [CNT_W-1:0] hold_cnt,
  output logic             timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] ptr;        // highest-priority index for the next arbitration

  logic       any_req;
  logic [1:0] win_idx;
  logic       own_done;
  logic       own_req;
  logic       hold_max;
  logic       release_now;

  // Rotating priority search: first set request bit starting at ptr.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    found   = 1'b0;
    win_idx = ptr;
    idx     = ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    any_req = found;
  end

  // Release causes for the current owner; bits of other requesters are ignored.
  always_comb begin
    own_done    = done[owner_id];
    own_req     = req[owner_id];
    hold_max    = (hold_cnt == CNT_W'(MAX_HOLD));
    release_now = own_done || !own_req || hold_max;
  end

  // Ownership state machine with all outputs registered.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses non-blocking assignment so all reads in
    // this block see the values from before the edge, whatever the line order.
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      grant    <= '0;
      busy     <= 1'b0;
      owner_id <= 2'd0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (enable && any_req) begin
            state    <= OWN;
            grant    <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            busy     <= 1'b1;
            owner_id <= win_idx;
            hold_cnt <= CNT_W'(1);
          end
        end
        OWN: begin
          if (release_now) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            ptr      <= owner_id + 2'd1;
            // Done and request-drop take priority, so only a pure forced
            // release is flagged.
            timeout  <= !own_done && own_req;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
            timeout  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_lock_scheduler.sv
// Directed testbench for rr_lock_scheduler with hand-computed expectations.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_rr_lock_scheduler;

  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 16;
  localparam int CNT_W    = 8;

  logic             clk;
  logic             rst;
  logic             enable;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  done;
  logic [NREQ-1:0]  grant;
  logic             busy;
  logic [1:0]       owner_id;
  logic [CNT_W-1:0] hold_cnt;
  logic             timeout;

  int n_checks = 0;
  int n_fail   = 0;

  rr_lock_scheduler #(
    .NREQ     (NREQ),
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .busy     (busy),
    .owner_id (owner_id),
    .hold_cnt (hold_cnt),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_timeout);
    check({tag, " grant"}, 32'(grant), 32'h0);
    check({tag, " busy"}, 32'(busy), 32'h0);
    check({tag, " hold_cnt"}, 32'(hold_cnt), 32'h0);
    check({tag, " timeout"}, 32'(timeout), 32'(exp_timeout));
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    req    = '0;
    done   = '0;

    // Reset state
    tick();
    check_idle("reset", 1'b0);
    check("reset owner_id", 32'(owner_id), 32'h0);
    rst = 1'b0;

    // All requesting, each owner pulses done in its third grant cycle:
    // grants 0,1,2,3,0, three cycles high then one dead cycle.
    enable = 1'b1;
    req    = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      logic [1:0] o;
      o = 2'(n % 4);
      tick();
      check($sformatf("rr%0d grant", n), 32'(grant), 32'(4'b0001 << o));
      check($sformatf("rr%0d owner", n), 32'(owner_id), 32'(o));
      check($sformatf("rr%0d hold1", n), 32'(hold_cnt), 32'd1);
      check($sformatf("rr%0d busy", n), 32'(busy), 32'h1);
      tick();
      check($sformatf("rr%0d hold2", n), 32'(hold_cnt), 32'd2);
      tick();
      check($sformatf("rr%0d grant c3", n), 32'(grant), 32'(4'b0001 << o));
      check($sformatf("rr%0d hold3", n), 32'(hold_cnt), 32'd3);
      done = 4'b0001 << o;
      tick();
      done = '0;
      check_idle($sformatf("rr%0d dead", n), 1'b0);
      check($sformatf("rr%0d owner kept", n), 32'(owner_id), 32'(o));
    end
    // ptr is now 1

    // Single requester held past MAX_HOLD: forced release and timeout pulse
    req = 4'b0100;
    for (int k = 1; k <= MAX_HOLD; k++) begin
      tick();
      check($sformatf("hold%0d grant", k), 32'(grant), 32'h4);
      check($sformatf("hold%0d cnt", k), 32'(hold_cnt), 32'(k));
      check($sformatf("hold%0d timeout", k), 32'(timeout), 32'h0);
    end
    tick();
    check_idle("forced release", 1'b1);
    tick();
    check("regrant grant", 32'(grant), 32'h4);
    check("regrant timeout", 32'(timeout), 32'h0);
    check("regrant hold", 32'(hold_cnt), 32'd1);
    req = '0;
    tick();
    check_idle("drop release", 1'b0);
    // ptr is now 3

    // Owner 1 ignores foreign done, other req bits and enable
    req = 4'b0010;
    tick();
    check("own1 grant", 32'(grant), 32'h2);
    done   = 4'b1001;
    req    = 4'b0110;
    enable = 1'b0;
    tick();
    check("own1 ignore grant", 32'(grant), 32'h2);
    check("own1 ignore hold", 32'(hold_cnt), 32'd2);
    done = '0;
    req  = 4'b0010;
    tick();
    check("own1 hold3", 32'(hold_cnt), 32'd3);
    enable = 1'b1;
    req    = 4'b0000;
    tick();
    check_idle("own1 drop", 1'b0);
    req = 4'b1111;  // ptr=2 must select requester 2
    tick();
    check("ptr2 grant", 32'(grant), 32'h4);
    check("ptr2 owner", 32'(owner_id), 32'd2);
    req = '0;
    tick();  // ptr is now 3

    // Priority after wrap
    req = 4'b1000;
    tick();
    check("wrap own3", 32'(grant), 32'h8);
    req = 4'b0011;
    tick();
    check_idle("wrap rel3", 1'b0);
    tick();
    check("wrap grant0", 32'(grant), 32'h1);
    done = 4'b0001;
    tick();
    done = '0;
    check_idle("wrap rel0", 1'b0);
    tick();
    check("wrap grant1", 32'(grant), 32'h2);
    req = '0;
    tick();  // ptr is now 2

    // enable low blocks new grants
    enable = 1'b0;
    req    = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("disabled%0d grant", k), 32'(grant), 32'h0);
    end
    enable = 1'b1;
    tick();
    check("enabled grant", 32'(grant), 32'h8);
    req = '0;
    tick();  // ptr is now 0

    // Move ptr to 1, then reset mid-ownership of requester 2
    req = 4'b0001;
    tick();
    check("pre-rst grant0", 32'(grant), 32'h1);
    req = '0;
    tick();  // ptr is now 1
    req = 4'b0100;
    tick();
    check("pre-rst grant2", 32'(grant), 32'h4);
    repeat (4) tick();
    check("pre-rst hold5", 32'(hold_cnt), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mid rst", 1'b0);
    check("mid rst owner", 32'(owner_id), 32'h0);
    req = 4'b0101;
    tick();
    check("post-rst grant", 32'(grant), 32'h1);

    // done coinciding with the hold limit is not a timeout
    repeat (MAX_HOLD - 1) tick();
    check("limit hold", 32'(hold_cnt), 32'(MAX_HOLD));
    done = 4'b0001;
    tick();
    done = '0;
    check_idle("done at limit", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
